// File: rtl/mem_arbiter.sv
// Two-port arbiter between the dcache command queue and the icache miss port onto a single memory bus.
// Routes accept tags to the granted requester and completion tags to the cache that owns each load tag.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  dcache2mem_command,
  input  logic [63:0] dcache2mem_addr,
  input  logic [63:0] dcache2mem_data,
  input  logic [1:0]  icache2mem_command,
  input  logic [63:0] icache2mem_addr,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  mem2dcache_response,
  output logic [3:0]  mem2icache_response,
  output logic [3:0]  mem2dcache_tag,
  output logic [3:0]  mem2icache_tag,
  output logic [63:0] mem2cache_data,
  output logic        grant_icache,
  output logic        mem_idle
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [15:1] valid;
  logic [15:1] owner;

  logic dcache_req, icache_req, starved;
  logic grant_d, grant_i;
  logic resp_nz, record_load, cpl_hit;

  always_comb begin
    dcache_req  = (dcache2mem_command == BUS_LOAD) || (dcache2mem_command == BUS_STORE);
    icache_req  = (icache2mem_command == BUS_LOAD);
    starved     = (starve_cnt >= LIMIT);
    grant_i     = !reset && icache_req && (!dcache_req || starved);
    grant_d     = !reset && dcache_req && !grant_i;
    resp_nz     = (mem2proc_response != 4'd0);
    record_load = resp_nz && ((grant_d && dcache2mem_command == BUS_LOAD) || grant_i);
    // Tag 0 means "no completion"; the guard keeps the table lookup in range.
    cpl_hit     = !reset && (mem2proc_tag != 4'd0) && valid[mem2proc_tag];
  end

  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = 64'd0;
    proc2mem_data       = 64'd0;
    mem2dcache_response = 4'd0;
    mem2icache_response = 4'd0;
    mem2dcache_tag      = 4'd0;
    mem2icache_tag      = 4'd0;
    mem2cache_data      = mem2proc_data;
    grant_icache        = grant_i;
    mem_idle            = reset || (!(|valid) && !dcache_req && !icache_req);
    if (grant_d) begin
      proc2mem_command    = dcache2mem_command;
      proc2mem_addr       = dcache2mem_addr;
      proc2mem_data       = dcache2mem_data;
      mem2dcache_response = mem2proc_response;
    end else if (grant_i) begin
      proc2mem_command    = BUS_LOAD;
      proc2mem_addr       = icache2mem_addr;
      mem2icache_response = mem2proc_response;
    end
    if (cpl_hit) begin
      if (owner[mem2proc_tag]) mem2icache_tag = mem2proc_tag;
      else                     mem2dcache_tag = mem2proc_tag;
    end
  end

  // A same-cycle completion and reissue of one tag: the later set overrides the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid      <= '0;
      starve_cnt <= 4'd0;
    end else begin
      if (cpl_hit) valid[mem2proc_tag] <= 1'b0;
      if (record_load) begin
        valid[mem2proc_response] <= 1'b1;
        owner[mem2proc_response] <= grant_i;
      end
      if (!icache_req || (grant_i && resp_nz)) starve_cnt <= 4'd0;
      else if (starve_cnt != 4'd15)            starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule
